// File: rtl/ysyx_23060184_rf_pkg.sv
// Shared types and constants for the multi-port NPC register file.
package ysyx_23060184_rf_pkg;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

  localparam logic [31:0] RF_ZERO_VAL = 32'h0;

  // Syscall-number register: a5 on RV32E, a7 on RV32I
  localparam int RF_A5_E = 15;
  localparam int RF_A7_I = 17;

endpackage

// File: rtl/ysyx_23060184_rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on write-back, issue wins on collision.
// Lookups are combinational and forced to 0 outside RUN; x0 is never busy.
module ysyx_23060184_rf_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int NR_READ    = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_run,
  input  logic                          i_set_en,
  input  logic [ADDR_WIDTH-1:0]         i_set_idx,
  input  logic                          i_clr_en,
  input  logic [ADDR_WIDTH-1:0]         i_clr_idx,
  input  logic [NR_READ*ADDR_WIDTH-1:0] i_look_idx,
  output logic [NR_READ-1:0]            o_busy
);

  localparam int NUM = 1 << ADDR_WIDTH;

  logic [NUM-1:0] r_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= '0;
    end else if (i_run) begin
      for (int j = 1; j < NUM; j++) begin
        if (i_set_en && i_set_idx == ADDR_WIDTH'(j))
          r_busy[j] <= 1'b1;
        else if (i_clr_en && i_clr_idx == ADDR_WIDTH'(j))
          r_busy[j] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NR_READ; g++) begin : g_look
    assign o_busy[g] = i_run & r_busy[i_look_idx[g*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule

// File: rtl/ysyx_23060184_regfile_mp.sv
// Multi-read-port integer register file with post-reset clear sequence and busy scoreboard.
// Define YSYX_23060184_RF_BYPASS_EN to forward same-cycle write-back data to matching reads.
module ysyx_23060184_regfile_mp
  import ysyx_23060184_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2,
  parameter int ECALL_REG  = RF_A5_E
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  input  logic                          ecall,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  input  logic                          issue_en,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  output logic [NR_READ-1:0]            rbusy,
  output logic                          ready
);

  localparam int NUM = 1 << ADDR_WIDTH;

  rf_state_t               r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_mem [1:NUM-1];

  logic                          w_run;
  logic [ADDR_WIDTH-1:0]         w_eff [NR_READ];
  logic [NR_READ*ADDR_WIDTH-1:0] w_eff_pk;
  logic [NR_READ-1:0]            w_sb_busy;

  assign w_run = (r_state == RF_RUN);
  assign ready = r_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RF_CLEAR;
      r_cnt   <= ADDR_WIDTH'(1);
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          r_cnt <= r_cnt + ADDR_WIDTH'(1);
          if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
            r_state <= RF_RUN;
            r_ready <= 1'b1;
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  // Entry 0 has no storage; the counter never points at it during CLEAR.
  always_ff @(posedge clk) begin
    if (!w_run)
      r_mem[r_cnt] <= DATA_WIDTH'(RF_ZERO_VAL);
    else if (wen && waddr != '0)
      r_mem[waddr] <= wdata;
  end

  for (genvar g = 0; g < NR_READ; g++) begin : g_rd
    logic [DATA_WIDTH-1:0] w_stored;

    if (g == 1) begin : g_ecall
      assign w_eff[g] = ecall ? ADDR_WIDTH'(ECALL_REG) : raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin : g_plain
      assign w_eff[g] = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    assign w_eff_pk[g*ADDR_WIDTH +: ADDR_WIDTH] = w_eff[g];
    assign w_stored = (!w_run || w_eff[g] == '0) ? '0 : r_mem[w_eff[g]];

`ifdef YSYX_23060184_RF_BYPASS_EN
    logic w_byp;
    assign w_byp = w_run && wen && (waddr != '0) && (waddr == w_eff[g]);
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = w_byp ? wdata : w_stored;
    // A same-cycle reissue of the forwarded register keeps it busy
    assign rbusy[g] = w_byp ? (issue_en && issue_rd == w_eff[g]) : w_sb_busy[g];
`else
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = w_stored;
    assign rbusy[g] = w_sb_busy[g];
`endif
  end

  ysyx_23060184_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NR_READ    (NR_READ)
  ) u_scoreboard (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_run      (w_run),
    .i_set_en   (issue_en),
    .i_set_idx  (issue_rd),
    .i_clr_en   (wen),
    .i_clr_idx  (waddr),
    .i_look_idx (w_eff_pk),
    .o_busy     (w_sb_busy)
  );

endmodule

// File: tb/tb_ysyx_23060184_regfile_mp.sv
// Directed bench for ysyx_23060184_regfile_mp (default parameters, 2 read ports).
// Expectations for same-cycle reads follow YSYX_23060184_RF_BYPASS_EN when it is defined.
module tb_ysyx_23060184_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic        ecall;
  logic [63:0] rdata;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [1:0]  rbusy;
  logic        ready;

  int n_assert = 0;
  int n_fail   = 0;
  int n_clr;

  ysyx_23060184_regfile_mp dut (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .ecall    (ecall),
    .rdata    (rdata),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .rbusy    (rbusy),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
    raddr = {p1, p0};
  endtask

  task automatic idle();
    wen = 1'b0; issue_en = 1'b0; ecall = 1'b0;
  endtask

  // Counts cycles with ready=0, bounded; also spot-checks outputs mid-CLEAR.
  task automatic count_clear(output int n);
    n = 0;
    while (!ready && n < 40) begin
      n++;
      if (n == 16) begin
        chk("clear_rdata0", rdata[31:0], 32'h0);
        chk("clear_rbusy", {30'h0, rbusy}, 32'h0);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; idle(); waddr = '0; wdata = '0; issue_rd = '0; rd(0, 0);
    #3;
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_rbusy", {30'h0, rbusy}, 32'h0);
    tick();

    // Writes and issues during CLEAR must be ignored
    wen = 1'b1; waddr = 5'd3; wdata = 32'hDEAD; issue_en = 1'b1; issue_rd = 5'd3; rd(3, 3);
    rst = 1'b0;
    count_clear(n_clr);
    chk("clear_cycles", n_clr, 32'd31);
    chk("run_ready", {31'h0, ready}, 32'h1);
    idle(); #1;
    chk("x3_after_clear", rdata[31:0], 32'h0);
    chk("x3_not_busy", {30'h0, rbusy}, 32'h0);

    wen = 1'b1; waddr = 5'd5; wdata = 32'h12345678; rd(5, 0); #1;
`ifdef YSYX_23060184_RF_BYPASS_EN
    chk("x5_same_cycle", rdata[31:0], 32'h12345678);
`else
    chk("x5_same_cycle", rdata[31:0], 32'h0);
`endif
    tick(); wen = 1'b0; #1;
    chk("x5_next_cycle", rdata[31:0], 32'h12345678);

    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; rd(0, 0); #1;
    chk("x0_bypass_blocked", rdata[31:0], 32'h0);
    tick(); wen = 1'b0; #1;
    chk("x0_port0", rdata[31:0], 32'h0);
    chk("x0_port1", rdata[63:32], 32'h0);

    wen = 1'b1; waddr = 5'd15; wdata = 32'hCAFE;
    tick(); wen = 1'b0; rd(5, 0); ecall = 1'b1; #1;
    chk("ecall_port1", rdata[63:32], 32'hCAFE);
    chk("ecall_port0_untouched", rdata[31:0], 32'h12345678);
    ecall = 1'b0; #1;
    chk("no_ecall_port1", rdata[63:32], 32'h0);
    rd(15, 15); #1;
    chk("same_idx_p0", rdata[31:0], 32'hCAFE);
    chk("same_idx_p1", rdata[63:32], 32'hCAFE);

    issue_en = 1'b1; issue_rd = 5'd7; rd(7, 7); #1;
    chk("busy_before_edge", {30'h0, rbusy}, 32'h0);
    tick(); issue_en = 1'b0; #1;
    chk("busy_x7_set", {30'h0, rbusy}, 32'h3);

    wen = 1'b1; waddr = 5'd7; wdata = 32'h77; issue_en = 1'b1; issue_rd = 5'd7; #1;
    chk("collide_busy_now", {31'h0, rbusy[0]}, 32'h1);
`ifdef YSYX_23060184_RF_BYPASS_EN
    chk("collide_data_now", rdata[31:0], 32'h77);
`else
    chk("collide_data_now", rdata[31:0], 32'h0);
`endif
    tick(); idle(); #1;
    chk("collide_busy_kept", {30'h0, rbusy}, 32'h3);
    chk("collide_data", rdata[31:0], 32'h77);

    wen = 1'b1; waddr = 5'd7; wdata = 32'h78; issue_en = 1'b1; issue_rd = 5'd8; rd(7, 8);
    tick(); idle(); #1;
    chk("split_busy", {30'h0, rbusy}, 32'h2);
    chk("split_data", rdata[31:0], 32'h78);
    wen = 1'b1; waddr = 5'd8; wdata = 32'h88;
    tick(); wen = 1'b0; #1;
    chk("x8_released", {30'h0, rbusy}, 32'h0);

    wen = 1'b1; waddr = 5'd9; wdata = 32'h1111; issue_en = 1'b1; issue_rd = 5'd9;
    tick(); idle(); rd(9, 0); #1;
    chk("x9_old", rdata[31:0], 32'h1111);
    chk("x9_busy", {31'h0, rbusy[0]}, 32'h1);
    wen = 1'b1; waddr = 5'd9; wdata = 32'hA5A5; #1;
`ifdef YSYX_23060184_RF_BYPASS_EN
    chk("x9_wb_data", rdata[31:0], 32'hA5A5);
    chk("x9_wb_busy", {31'h0, rbusy[0]}, 32'h0);
`else
    chk("x9_wb_data", rdata[31:0], 32'h1111);
    chk("x9_wb_busy", {31'h0, rbusy[0]}, 32'h1);
`endif
    tick(); wen = 1'b0; #1;
    chk("x9_new", rdata[31:0], 32'hA5A5);
    chk("x9_free", {31'h0, rbusy[0]}, 32'h0);

    wen = 1'b1; waddr = 5'd10; wdata = 32'hA;
    tick(); wen = 1'b0; rd(10, 0); #1;
    chk("x10_data", rdata[31:0], 32'hA);
    chk("x10_never_busy", {31'h0, rbusy[0]}, 32'h0);

    wen = 1'b1; waddr = 5'd4; wdata = 32'h1; issue_en = 1'b1; issue_rd = 5'd4;
    tick(); idle(); rd(4, 4); #1;
    chk("x4_data", rdata[31:0], 32'h1);
    chk("x4_busy", {30'h0, rbusy}, 32'h3);
    #1 rst = 1'b1; #1;
    chk("async_ready", {31'h0, ready}, 32'h0);
    chk("async_rbusy", {30'h0, rbusy}, 32'h0);
    chk("async_rdata", rdata[31:0], 32'h0);
    tick(); rst = 1'b0;

    // Reset again part-way through CLEAR: the full sequence restarts
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1; #2; rst = 1'b0;
    count_clear(n_clr);
    chk("reclear_cycles", n_clr, 32'd31);
    chk("reclear_ready", {31'h0, ready}, 32'h1);
    rd(4, 5); #1;
    chk("x4_cleared", rdata[31:0], 32'h0);
    chk("x5_cleared", rdata[63:32], 32'h0);
    chk("x4_busy_cleared", {30'h0, rbusy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
